// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch prediction queue with resolve, PHT update and redirect
// Fetch pushes predictions; the confirming stage pops the oldest entry with its actual outcome.
module branch_resolve_queue #(
  parameter int DEPTH           = 8,
  parameter int PC_WIDTH        = 32,
  parameter int PHT_INDEX_WIDTH = 10,
  localparam int AW             = $clog2(DEPTH),
  localparam int CW             = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [PC_WIDTH-1:0]        push_pc,
  input  logic [PHT_INDEX_WIDTH-1:0] push_pht_index,
  input  logic                       push_pred_taken,
  input  logic [PC_WIDTH-1:0]        push_pred_target,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic [PC_WIDTH-1:0]        resolve_target,
  output logic                       upd_valid,
  output logic [PHT_INDEX_WIDTH-1:0] upd_pht_index,
  output logic                       upd_taken,
  output logic                       mispredict,
  output logic [PC_WIDTH-1:0]        redirect_pc,
  output logic [CW-1:0]              count,
  output logic                       underflow_err
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [PC_WIDTH-1:0]        pcMem     [DEPTH];
  logic [PHT_INDEX_WIDTH-1:0] idxMem    [DEPTH];
  logic                       takenMem  [DEPTH];
  logic [PC_WIDTH-1:0]        targetMem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   rdPtr;
  logic [AW:0]   wrPtr;
  logic [AW-1:0] rdIdx;
  logic [AW-1:0] wrIdx;
  logic          empty;
  logic          full;

  logic                       doPop;
  logic                       doPush;
  logic                       headMis;
  logic [PC_WIDTH-1:0]        headPc;
  logic [PHT_INDEX_WIDTH-1:0] headIdx;
  logic                       headPredTaken;
  logic [PC_WIDTH-1:0]        headPredTarget;
  logic [PC_WIDTH-1:0]        nextRedirect;

  assign rdIdx = rdPtr[AW-1:0];
  assign wrIdx = wrPtr[AW-1:0];
  assign empty = (rdPtr == wrPtr);
  assign full  = (rdIdx == wrIdx) && (rdPtr[AW] != wrPtr[AW]);

  assign headPc         = pcMem[rdIdx];
  assign headIdx        = idxMem[rdIdx];
  assign headPredTaken  = takenMem[rdIdx];
  assign headPredTarget = targetMem[rdIdx];

  assign headMis = (resolve_taken != headPredTaken) ||
                   (resolve_taken && (resolve_target != headPredTarget));
  assign nextRedirect = resolve_taken ? resolve_target : headPc + PC_WIDTH'(4);

  // Flush drops everything; a mispredicting pop makes any same-cycle push wrong-path.
  assign doPop  = resolve_valid && !empty && !flush;
  assign doPush = push_valid && !full && !flush && !(doPop && headMis);

  assign push_ready = !full;
  assign count      = CW'(wrPtr - rdPtr);

  always_ff @(posedge clk) begin
    if (doPush) begin
      pcMem[wrIdx]     <= push_pc;
      idxMem[wrIdx]    <= push_pht_index;
      takenMem[wrIdx]  <= push_pred_taken;
      targetMem[wrIdx] <= push_pred_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
    end else if (flush) begin
      wrPtr <= rdPtr;
    end else if (doPop && headMis) begin
      rdPtr <= rdPtr + PTR_ONE;
      wrPtr <= rdPtr + PTR_ONE;
    end else begin
      if (doPop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      if (doPush) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_valid     <= 1'b0;
      upd_pht_index <= '0;
      upd_taken     <= 1'b0;
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      underflow_err <= 1'b0;
    end else begin
      upd_valid  <= doPop;
      mispredict <= doPop && headMis;
      if (doPop) begin
        upd_pht_index <= headIdx;
        upd_taken     <= resolve_taken;
        redirect_pc   <= nextRedirect;
      end
      if (resolve_valid && empty && !flush) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - scoreboard bench for branch_resolve_queue
// Driver pushes per-cycle expectations from a queue model; a negedge monitor compares.
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [9:0]  push_pht_index;
  logic        push_pred_taken;
  logic [31:0] push_pred_target;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        upd_valid;
  logic [9:0]  upd_pht_index;
  logic        upd_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  count;
  logic        underflow_err;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_WIDTH(32), .PHT_INDEX_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
    .push_pht_index(push_pht_index), .push_pred_taken(push_pred_taken),
    .push_pred_target(push_pred_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .upd_valid(upd_valid), .upd_pht_index(upd_pht_index), .upd_taken(upd_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .count(count),
    .underflow_err(underflow_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [9:0]  idx;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic        upd;
    logic [9:0]  idx;
    logic        taken;
    logic        mis;
    logic [31:0] redir;
    int          cnt;
    logic        ready;
    logic        uf;
  } exp_t;

  ent_t        mq[$];
  exp_t        expQ[$];
  logic [31:0] mRedir;
  logic        mUf;
  int          tests;
  int          fails;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("upd_valid", 64'(upd_valid), 64'(e.upd));
        chk("mispredict", 64'(mispredict), 64'(e.mis));
        chk("count", 64'(count), 64'(e.cnt));
        chk("push_ready", 64'(push_ready), 64'(e.ready));
        chk("underflow_err", 64'(underflow_err), 64'(e.uf));
        chk("redirect_pc", 64'(redirect_pc), 64'(e.redir));
        if (e.upd) begin
          chk("upd_pht_index", 64'(upd_pht_index), 64'(e.idx));
          chk("upd_taken", 64'(upd_taken), 64'(e.taken));
        end
      end
    end
  end

  task automatic step(input logic pv, input logic [31:0] pc, input logic [9:0] idx,
                      input logic pt, input logic [31:0] tgt,
                      input logic rv, input logic rt, input logic [31:0] rtgt, input logic fl);
    exp_t e;
    ent_t h;
    ent_t n;
    logic acc;
    push_valid = pv; push_pc = pc; push_pht_index = idx;
    push_pred_taken = pt; push_pred_target = tgt;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt; flush = fl;
    n.pc = pc; n.idx = idx; n.pt = pt; n.tgt = tgt;
    acc = pv && (mq.size() < DEPTH);
    e.upd = 1'b0; e.mis = 1'b0; e.idx = '0; e.taken = 1'b0;
    if (fl) begin
      mq.delete();
    end else if (rv && mq.size() > 0) begin
      h = mq.pop_front();
      e.upd = 1'b1;
      e.idx = h.idx;
      e.taken = rt;
      e.mis = (rt != h.pt) || (rt && rtgt != h.tgt);
      mRedir = rt ? rtgt : h.pc + 32'd4;
      if (e.mis) mq.delete();
      else if (acc) mq.push_back(n);
    end else begin
      if (rv) mUf = 1'b1;
      if (acc) mq.push_back(n);
    end
    e.cnt = mq.size();
    e.ready = (mq.size() < DEPTH);
    e.uf = mUf;
    e.redir = mRedir;
    @(posedge clk);
    expQ.push_back(e);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic pushOne(input logic [31:0] pc, input logic [9:0] idx, input logic pt, input logic [31:0] tgt);
    step(1'b1, pc, idx, pt, tgt, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic resolveOne(input logic rt, input logic [31:0] rtgt);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, rt, rtgt, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0; push_valid = 1'b0; resolve_valid = 1'b0;
    mq.delete(); mRedir = '0; mUf = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic        pv, pt, rv, rt, fl;
    logic [31:0] pc, tgt, rtgt;
    tests = 0; fails = 0;
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_pc = '0; push_pht_index = '0;
    push_pred_taken = 1'b0; push_pred_target = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
    mRedir = '0; mUf = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_upd_valid", 64'(upd_valid), 64'd0);
    chk("reset_push_ready", 64'(push_ready), 64'd1);
    doReset();

    // 1: correct taken prediction
    pushOne(32'h100, 10'd5, 1'b1, 32'h200);
    resolveOne(1'b1, 32'h200);
    idle();

    // 2: not-taken predictions, head actually taken; wrong-path push dropped
    pushOne(32'h10, 10'd1, 1'b0, 32'h0);
    pushOne(32'h20, 10'd2, 1'b0, 32'h0);
    pushOne(32'h30, 10'd3, 1'b0, 32'h0);
    step(1'b1, 32'h40, 10'd4, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 1'b0);
    idle();

    // 3: predicted taken, actually not taken -> pc+4
    pushOne(32'h80, 10'd9, 1'b1, 32'h90);
    resolveOne(1'b0, 32'h0);
    idle();

    // 4: fill, overflow push, pop+push at and below full, FIFO order across wrap
    for (int i = 0; i < DEPTH; i++) pushOne(32'h1000 + 32'(i * 4), 10'(16 + i), 1'b0, '0);
    pushOne(32'h2000, 10'd99, 1'b0, '0);
    step(1'b1, 32'h3000, 10'd50, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 12; i++)
      step(1'b1, 32'h4000 + 32'(i * 4), 10'(60 + i), 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) resolveOne(1'b0, '0);
    idle();

    // 5: underflow is sticky; flush drops concurrent resolve
    doReset();
    resolveOne(1'b1, 32'h500);
    idle();
    for (int i = 0; i < 4; i++) pushOne(32'h600 + 32'(i * 4), 10'(i), 1'b1, 32'h700);
    step(1'b1, 32'h999, 10'd7, 1'b0, '0, 1'b1, 1'b1, 32'h700, 1'b1);
    idle();

    // 6: asynchronous reset mid-stream, then first push lands in slot 0
    for (int i = 0; i < 5; i++) pushOne(32'h800 + 32'(i * 4), 10'(100 + i), 1'b0, '0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("async_count", 64'(count), 64'd0);
    chk("async_upd_valid", 64'(upd_valid), 64'd0);
    chk("async_mispredict", 64'(mispredict), 64'd0);
    chk("async_redirect", 64'(redirect_pc), 64'd0);
    chk("async_underflow", 64'(underflow_err), 64'd0);
    chk("async_push_ready", 64'(push_ready), 64'd1);
    mq.delete(); mRedir = '0; mUf = 1'b0;
    flush = 1'b0; push_valid = 1'b0; resolve_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pushOne(32'hA00, 10'h2A, 1'b1, 32'hB00);
    resolveOne(1'b1, 32'hB00);
    idle();

    // Random traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      fl = ($urandom_range(0, 63) == 0);
      pv = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 4);
      pt = 1'($urandom_range(0, 1));
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 4095), 2'b00};
      tgt = {$urandom_range(0, 15), 2'b00};
      if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
        rt = mq[0].pt;
        rtgt = mq[0].tgt;
      end else begin
        rt = 1'($urandom_range(0, 1));
        rtgt = {$urandom_range(0, 15), 2'b00};
      end
      step(pv, pc, 10'($urandom_range(0, 1023)), pt, tgt, rv, rt, rtgt, fl);
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
